// File: rtl/camlink_pkg.sv
// Shared definitions for the Camera Link frame transmitter.
// Holds the transmitter state encoding, default widths and small helpers
// used by both the top level and the blanking counter.
package camlink_pkg;

    localparam int unsigned PixelWDefault = 24;  // pixel bits per stream beat
    localparam int unsigned CntWDefault   = 16;  // geometry / blanking counter width
    localparam int unsigned AxisDataW     = 64;  // width of the DMA stream data bus

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StVbPre  = 3'd1,
        StLine   = 3'd2,
        StHb     = 3'd3,
        StVbPost = 3'd4
    } state_e;

    // States during which the frame-valid strobe is raised.
    function automatic logic state_in_frame(state_e s);
        return (s == StLine) || (s == StHb);
    endfunction

endpackage

// File: rtl/blank_counter.sv
// Down-counter that times the blanking intervals (pre-frame, line gap and
// post-frame gaps).
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   load_i  : load a new interval length (takes priority over count_i)
//   len_i   : interval length in cycles; 0 is treated as 1
//   count_i : decrement while the interval is running
//   done_o  : high on the final cycle of the interval
module blank_counter #(
    parameter int unsigned CNT_W = camlink_pkg::CntWDefault
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic             count_i,
    output logic             done_o
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter holds "cycles remaining after this one", so an interval of
    // N cycles loads N-1 and finishes when it reads zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = (len_i == '0) ? '0 : len_i - CntOne;
        end else if (count_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntOne;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/camlink_frame_tx.sv
// Camera Link frame transmitter: turns a one-pixel-per-beat DMA stream into
// the FVAL/LVAL/DVAL framed parallel word, inserting vertical and horizontal
// blanking. Back-pressure from the stream shows up as DVAL gaps inside a line.
//   sys_clk, sys_rst_n                : clock, async active-low reset
//   start                             : request one frame (ignored while busy)
//   image_width/height, hblank/vblank : frame geometry, latched on start
//   s_axis_*                          : pixel stream in (tready only in LINE)
//   pixel, fval, lval, dval           : Camera Link word, one cycle after the beat
//   busy, frame_done, frame_err       : status (done pulses, err is sticky)
module camlink_frame_tx
    import camlink_pkg::*;
#(
    parameter int unsigned PIXEL_W = PixelWDefault,
    parameter int unsigned CNT_W   = CntWDefault
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     image_width,
    input  logic [CNT_W-1:0]     image_height,
    input  logic [CNT_W-1:0]     hblank,
    input  logic [CNT_W-1:0]     vblank,
    input  logic [AxisDataW-1:0] s_axis_tdata,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tlast,
    output logic                 s_axis_tready,
    output logic [PIXEL_W-1:0]   pixel,
    output logic                 fval,
    output logic                 lval,
    output logic                 dval,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 frame_err
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    // Reset asserts asynchronously but is released on a clock edge.
    logic rst_meta_q, rst_sync_q, rst_n_int;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    assign rst_n_int = rst_sync_q;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   width_q, height_q, hblank_q, vblank_q;
    logic [CNT_W-1:0]   col_q, col_d, row_q, row_d;
    logic [PIXEL_W-1:0] pixel_q;
    logic               fval_q, lval_q, dval_q, err_q, err_d;

    logic               start_acc, beat, last_col, last_row, done_pulse;
    logic               bc_load, bc_count, bc_done;
    logic [CNT_W-1:0]   bc_len;
    logic               unused_tdata;

    assign unused_tdata = ^s_axis_tdata[AxisDataW-1:PIXEL_W];

    assign start_acc = (state_q == StIdle) && start &&
                       (image_width != '0) && (image_height != '0);
    assign beat      = (state_q == StLine) && s_axis_tvalid;
    assign last_col  = (col_q == width_q - CntOne);
    assign last_row  = (row_q == height_q - CntOne);
    assign bc_count  = (state_q == StVbPre) || (state_q == StHb) || (state_q == StVbPost);

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        err_d      = err_q;
        bc_load    = 1'b0;
        bc_len     = hblank_q;
        done_pulse = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_acc) begin
                    state_d = StVbPre;
                    col_d   = '0;
                    row_d   = '0;
                    err_d   = 1'b0;
                    bc_load = 1'b1;
                    bc_len  = vblank;  // geometry registers load on this same edge
                end
            end
            StVbPre: begin
                if (bc_done) state_d = StLine;
            end
            StLine: begin
                if (beat) begin
                    // tlast must mark exactly the final pixel of the frame.
                    if (s_axis_tlast != (last_col && last_row)) err_d = 1'b1;
                    if (last_col) begin
                        col_d   = '0;
                        bc_load = 1'b1;
                        if (last_row) begin
                            state_d = StVbPost;
                            bc_len  = vblank_q;
                        end else begin
                            state_d = StHb;
                            row_d   = row_q + CntOne;
                        end
                    end else begin
                        col_d = col_q + CntOne;
                    end
                end
            end
            StHb: begin
                if (bc_done) state_d = StLine;
            end
            StVbPost: begin
                if (bc_done) begin
                    state_d    = StIdle;
                    done_pulse = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q  <= StIdle;
            width_q  <= '0;
            height_q <= '0;
            hblank_q <= '0;
            vblank_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
            err_q    <= 1'b0;
            pixel_q  <= '0;
            fval_q   <= 1'b0;
            lval_q   <= 1'b0;
            dval_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            err_q   <= err_d;
            if (start_acc) begin
                width_q  <= image_width;
                height_q <= image_height;
                hblank_q <= hblank;
                vblank_q <= vblank;
            end
            if (beat) pixel_q <= s_axis_tdata[PIXEL_W-1:0];
            // The word is registered, so it trails the state by one cycle.
            fval_q <= state_in_frame(state_q);
            lval_q <= (state_q == StLine);
            dval_q <= beat;
        end
    end

    blank_counter #(
        .CNT_W (CNT_W)
    ) u_blank_counter (
        .clk_i   (sys_clk),
        .rst_ni  (rst_n_int),
        .load_i  (bc_load),
        .len_i   (bc_len),
        .count_i (bc_count),
        .done_o  (bc_done)
    );

    assign s_axis_tready = (state_q == StLine);
    assign busy          = (state_q != StIdle);
    assign frame_done    = done_pulse;
    assign frame_err     = err_q;
    assign pixel         = pixel_q;
    assign fval          = fval_q;
    assign lval          = lval_q;
    assign dval          = dval_q;

endmodule

// File: tb/tb_camlink_frame_tx.sv
// Self-checking bench for camlink_frame_tx. Each frame is first expanded into
// a per-cycle list of abstract phases (gap / line idle / beat) from the frame
// rules; the stream source and all expected outputs are derived from that list.
module tb_camlink_frame_tx;

    localparam int PhIdle  = 0;
    localparam int PhPre   = 1;
    localparam int PhLIdle = 2;
    localparam int PhBeat  = 3;
    localparam int PhHGap  = 4;
    localparam int PhPost  = 5;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        start;
    logic [15:0] image_width, image_height, hblank, vblank;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [23:0] pixel;
    logic        fval, lval, dval, busy, frame_done, frame_err;

    int          n_vec = 0;
    int          n_err = 0;
    int          ph[$];
    logic [23:0] pd[$];
    logic        pl[$];
    logic        pbad[$];
    logic [23:0] exp_pix;

    always #5 sys_clk = ~sys_clk;

    camlink_frame_tx #(
        .PIXEL_W (24),
        .CNT_W   (16)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .start         (start),
        .image_width   (image_width),
        .image_height  (image_height),
        .hblank        (hblank),
        .vblank        (vblank),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .pixel         (pixel),
        .fval          (fval),
        .lval          (lval),
        .dval          (dval),
        .busy          (busy),
        .frame_done    (frame_done),
        .frame_err     (frame_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int at_least_one(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    task automatic push_ph(input int p, input logic [23:0] d, input logic l, input logic b);
        ph.push_back(p);
        pd.push_back(d);
        pl.push_back(l);
        pbad.push_back(b);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " pixel"}, pixel, 0);
        check({tag, " fval"}, fval, 0);
        check({tag, " lval"}, lval, 0);
        check({tag, " dval"}, dval, 0);
        check({tag, " tready"}, s_axis_tready, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " frame_done"}, frame_done, 0);
        check({tag, " frame_err"}, frame_err, 0);
    endtask

    // Transmit one frame. force_beat/force_cnt insert a fixed stall before
    // one beat; bad_beat flips tlast on that beat; restart_at pulses a second
    // start mid-frame; abort_at returns early so the caller can reset.
    task automatic run_frame(input int w, input int h, input int hb, input int vb,
                             input int stall_max, input int force_beat, input int force_cnt,
                             input int bad_beat, input int restart_at, input int abort_at);
        int   k;
        int   s;
        int   last_idx;
        int   prev;
        logic err_m;
        logic is_final;
        ph.delete();
        pd.delete();
        pl.delete();
        pbad.delete();
        push_ph(PhIdle, '0, 1'b0, 1'b0);
        repeat (at_least_one(vb)) push_ph(PhPre, '0, 1'b0, 1'b0);
        k = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                s = 0;
                if (stall_max > 0 && $urandom_range(2, 0) == 0) s = $urandom_range(stall_max, 1);
                if (k == force_beat) s = force_cnt;
                repeat (s) push_ph(PhLIdle, '0, 1'b0, 1'b0);
                is_final = (k == w * h - 1);
                push_ph(PhBeat, 24'($urandom), is_final ^ (k == bad_beat), k == bad_beat);
                k++;
            end
            if (r < h - 1) repeat (at_least_one(hb)) push_ph(PhHGap, '0, 1'b0, 1'b0);
            else repeat (at_least_one(vb)) push_ph(PhPost, '0, 1'b0, 1'b0);
        end
        push_ph(PhIdle, '0, 1'b0, 1'b0);
        push_ph(PhIdle, '0, 1'b0, 1'b0);
        last_idx = ph.size() - 3;
        err_m = 1'b0;

        for (int m = 0; m < ph.size(); m++) begin
            @(negedge sys_clk);
            if (m > 0) begin
                prev = ph[m-1];
                if (prev == PhBeat) exp_pix = pd[m-1];
                check("busy", busy, ph[m] != PhIdle);
                check("tready", s_axis_tready, (ph[m] == PhLIdle) || (ph[m] == PhBeat));
                check("frame_done", frame_done, m == last_idx);
                check("fval", fval, (prev == PhLIdle) || (prev == PhBeat) || (prev == PhHGap));
                check("lval", lval, (prev == PhLIdle) || (prev == PhBeat));
                check("dval", dval, prev == PhBeat);
                check("pixel", pixel, exp_pix);
                check("frame_err", frame_err, err_m);
            end
            if (m == abort_at) return;
            err_m = (m == 0) ? 1'b0 : (err_m | (ph[m] == PhBeat && pbad[m]));
            start = (m == 0) || (m == restart_at);
            if (m == 0) begin
                image_width  = 16'(w);
                image_height = 16'(h);
                hblank       = 16'(hb);
                vblank       = 16'(vb);
            end else begin
                image_width  = 16'($urandom_range(9, 0));
                image_height = 16'($urandom_range(9, 0));
                hblank       = 16'($urandom_range(9, 0));
                vblank       = 16'($urandom_range(9, 0));
            end
            s_axis_tdata  = {$urandom, $urandom};
            s_axis_tvalid = (ph[m] == PhBeat);
            s_axis_tlast  = (ph[m] == PhBeat) ? pl[m] : 1'($urandom);
            if (ph[m] == PhBeat) s_axis_tdata[23:0] = pd[m];
        end
        start = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (3) begin
            @(negedge sys_clk);
            check("post-reset busy", busy, 0);
            check("post-reset frame_done", frame_done, 0);
        end
    endtask

    initial begin
        int w, h;
        sys_rst_n     = 1'b0;
        start         = 1'b0;
        image_width   = '0;
        image_height  = '0;
        hblank        = '0;
        vblank        = '0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        exp_pix       = '0;
        #3;
        check_all_zero("reset");
        release_reset();

        // Continuous 4x2 frame with hblank=3, vblank=2.
        run_frame(4, 2, 3, 2, 0, -1, 0, -1, -1, -1);
        // 4x1 frame with a 3-cycle stall before the second beat.
        run_frame(4, 1, 2, 2, 0, 1, 3, -1, -1, -1);
        // Early tlast on beat 3 of a 4x2 frame; the following start clears it.
        run_frame(4, 2, 3, 2, 0, -1, 0, 2, -1, -1);
        run_frame(4, 2, 1, 1, 0, -1, 0, -1, -1, -1);

        // Start with zero width, then zero height: both ignored.
        @(negedge sys_clk);
        start = 1'b1;
        image_width = 16'd0;
        image_height = 16'd2;
        @(negedge sys_clk);
        check("zero-width busy", busy, 0);
        image_width = 16'd3;
        image_height = 16'd0;
        @(negedge sys_clk);
        check("zero-height busy", busy, 0);
        start = 1'b0;
        @(negedge sys_clk);
        check("zero-geom busy", busy, 0);

        // Second start while busy is ignored.
        run_frame(3, 2, 2, 1, 1, -1, 0, -1, 5, -1);

        // Reset in row 1 of a 4x2 frame with frame_err already set.
        run_frame(4, 2, 3, 2, 0, -1, 0, 0, -1, 11);
        #2;
        sys_rst_n = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        exp_pix = '0;
        check_all_zero("mid-frame reset");
        release_reset();
        run_frame(4, 2, 3, 2, 0, -1, 0, -1, -1, -1);

        // Zero blanking on a 2x2 frame: every gap is one cycle.
        run_frame(2, 2, 0, 0, 0, -1, 0, -1, -1, -1);

        // Randomized frames with stalls and occasional bad tlast.
        for (int i = 0; i < 8; i++) begin
            w = $urandom_range(6, 1);
            h = $urandom_range(4, 1);
            run_frame(w, h, $urandom_range(3, 0), $urandom_range(3, 0), 2, -1, 0,
                      ($urandom_range(2, 0) == 0) ? $urandom_range(w * h - 1, 0) : -1, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
